// File: rtl/t05_cb_controller_pkg.sv
// ----------------------------------------------------------------------------
// t05_cb_controller_pkg
// Shared types for the codebook pass: the codebook-synthesis state type, the
// memory-side controller state type, word counts for the two record types
// moved over the memory port, and a small address helper.
// ----------------------------------------------------------------------------
package t05_cb_controller_pkg;

  // States of the codebook synthesis engine that consumes h_element.
  typedef enum logic [2:0] {
    CB_INIT,
    CB_LEFT,
    CB_RIGHT,
    CB_SEND,
    CB_BACKTRACK,
    CB_FINISH
  } state_cb;

  // States of the memory-side controller feeding the synthesis engine.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRESENT,
    WRITE,
    ACK,
    DONE
  } cb_ctrl_state_t;

  // One htree element is 71 bits, spread over three 32-bit words.
  localparam int ELEM_WORDS = 3;
  // One codebook entry is a 128-bit path, stored as four 32-bit words.
  localparam int PATH_WORDS = 4;

  // Word offset of htree element idx: 3*idx built as (idx<<1)+idx so no
  // multiplier is inferred.
  function automatic logic [31:0] elem_offset(input logic [6:0] idx);
    logic [31:0] wide;
    wide = {25'd0, idx};
    return (wide << 1) + wide;
  endfunction

endpackage

// File: rtl/t05_cb_controller.sv
// ----------------------------------------------------------------------------
// t05_cb_controller
// Drives the memory port for the codebook pass. Fetches htree elements (three
// reads each) and presents them to codebook synthesis on h_element, then
// stores each leaf path the synthesis reports (four writes per entry) and
// acknowledges it with a one-cycle write_finish pulse.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   start           pulse, begins a pass from htree root max_index
//   max_index       htree root index
//   cb_index        htree index currently requested by synthesis
//   char_found      synthesis has a leaf (char_index, char_path) to store
//   char_index      leaf character
//   char_path       leaf path with leading control 1
//   cb_finished     synthesis has reached its final state
//   h_element       registered htree element fed to synthesis
//   write_finish    one-cycle pulse: codebook entry stored
//   mem_addr        word address
//   mem_rd, mem_wr  request strobes (never both high)
//   mem_wdata       write data
//   mem_rdata       read data, valid in the completing cycle
//   mem_busy        stall; transfer completes when strobe=1 and mem_busy=0
//   busy            high in every state except IDLE and DONE
//   done            high in DONE
// ----------------------------------------------------------------------------
module t05_cb_controller
  import t05_cb_controller_pkg::*;
#(
  parameter logic [31:0] HT_BASE = 32'h0000_0000,
  parameter logic [31:0] CB_BASE = 32'h0000_0400
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [6:0]   max_index,
  input  logic [6:0]   cb_index,
  input  logic         char_found,
  input  logic [7:0]   char_index,
  input  logic [127:0] char_path,
  input  logic         cb_finished,
  output logic [70:0]  h_element,
  output logic         write_finish,
  output logic [31:0]  mem_addr,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_busy,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] ELEM_LAST = 2'(ELEM_WORDS - 1);
  localparam logic [1:0] PATH_LAST = 2'(PATH_WORDS - 1);

  cb_ctrl_state_t state_reg, state_next;
  logic [6:0]     idx_reg, idx_next;
  logic [1:0]     wc_reg, wc_next;
  logic [7:0]     char_reg, char_next;
  logic [127:0]   path_reg, path_next;
  // First two element words are staged here so h_element changes only once,
  // when the whole element is in.
  logic [31:0]    word0_reg, word0_next;
  logic [31:0]    word1_reg, word1_next;
  logic [70:0]    elem_reg, elem_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      wc_reg    <= '0;
      char_reg  <= '0;
      path_reg  <= '0;
      word0_reg <= '0;
      word1_reg <= '0;
      elem_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      wc_reg    <= wc_next;
      char_reg  <= char_next;
      path_reg  <= path_next;
      word0_reg <= word0_next;
      word1_reg <= word1_next;
      elem_reg  <= elem_next;
    end
  end

  // Strobes, address and write data depend only on registered state, so they
  // stay put for as long as mem_busy stalls the transfer.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    wc_next      = wc_reg;
    char_next    = char_reg;
    path_next    = path_reg;
    word0_next   = word0_reg;
    word1_next   = word1_reg;
    elem_next    = elem_reg;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    write_finish = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          idx_next   = max_index;
          wc_next    = '0;
          state_next = FETCH;
        end
      end

      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = HT_BASE + elem_offset(idx_reg) + {30'd0, wc_reg};
        if (!mem_busy) begin
          if (wc_reg == ELEM_LAST) begin
            // Only the low 7 bits of the last word belong to the element.
            elem_next  = {mem_rdata[6:0], word1_reg, word0_reg};
            wc_next    = '0;
            state_next = PRESENT;
          end else begin
            if (wc_reg == 2'd0) begin
              word0_next = mem_rdata;
            end else begin
              word1_next = mem_rdata;
            end
            wc_next = wc_reg + 2'd1;
          end
        end
      end

      PRESENT: begin
        if (cb_finished) begin
          state_next = DONE;
        end else if (char_found) begin
          char_next  = char_index;
          path_next  = char_path;
          wc_next    = '0;
          state_next = WRITE;
        end else if (cb_index != idx_reg) begin
          idx_next   = cb_index;
          wc_next    = '0;
          state_next = FETCH;
        end
      end

      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = CB_BASE + {22'd0, char_reg, 2'b00} + {30'd0, wc_reg};
        mem_wdata = path_reg[{wc_reg, 5'd0} +: 32];
        if (!mem_busy) begin
          if (wc_reg == PATH_LAST) begin
            wc_next    = '0;
            state_next = ACK;
          end else begin
            wc_next = wc_reg + 2'd1;
          end
        end
      end

      ACK: begin
        write_finish = 1'b1;
        state_next   = PRESENT;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign h_element = elem_reg;
  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_t05_cb_controller.sv
`timescale 1ns/1ps
module tb_t05_cb_controller;

  localparam logic [31:0] HT_BASE = 32'h0000_0000;
  localparam logic [31:0] CB_BASE = 32'h0000_0400;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [6:0]   max_index = '0;
  logic [6:0]   cb_index = '0;
  logic         char_found = 1'b0;
  logic [7:0]   char_index = '0;
  logic [127:0] char_path = '0;
  logic         cb_finished = 1'b0;
  logic [70:0]  h_element;
  logic         write_finish;
  logic [31:0]  mem_addr;
  logic         mem_rd;
  logic         mem_wr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_busy = 1'b0;
  logic         busy;
  logic         done;

  t05_cb_controller #(.HT_BASE(HT_BASE), .CB_BASE(CB_BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .max_index(max_index),
    .cb_index(cb_index), .char_found(char_found), .char_index(char_index),
    .char_path(char_path), .cb_finished(cb_finished), .h_element(h_element),
    .write_finish(write_finish), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_busy(mem_busy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Word-addressed memory model; htree lives at 0.., codebook at 0x400..
  logic [31:0] mem [0:2047];
  assign mem_rdata = mem[mem_addr[10:0]];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          stamp;
  } xfer_t;

  xfer_t       xfer_q[$];
  int          cyc = 0;
  int          stall_mode = 0;   // 0: none, 1: two stall cycles, 2: random 0..2
  int          stall_left = -1;
  int          hold_cnt = 0;
  int          hold_bad = 0;
  int          wf_cnt = 0;
  logic        hold_pend = 1'b0;
  logic [65:0] hold_sig = '0;
  int          checks = 0;
  int          errors = 0;

  function automatic int pick_stall(input int mode);
    if (mode == 1) return 2;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  // Memory-side monitor/responder: logs completed transfers on the rising
  // edge, generates mem_busy and watches strobe stability on the falling edge.
  always @(clk) begin
    xfer_t xf;
    if (clk) begin
      cyc = cyc + 1;
      if (!rst && (mem_rd || mem_wr) && !mem_busy) begin
        xf.wr = mem_wr; xf.addr = mem_addr; xf.data = mem_wdata; xf.stamp = cyc;
        xfer_q.push_back(xf);
        stall_left = -1;
      end
    end else begin
      if (hold_pend) begin
        hold_cnt++;
        if ({mem_addr, mem_wdata, mem_rd, mem_wr} !== hold_sig) hold_bad++;
      end
      if (!rst && (mem_rd || mem_wr)) begin
        if (stall_left < 0) stall_left = pick_stall(stall_mode);
        mem_busy = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else begin
        mem_busy = 1'b0;
      end
      hold_pend = mem_busy;
      hold_sig  = {mem_addr, mem_wdata, mem_rd, mem_wr};
      if (write_finish) wf_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference element: three consecutive words, top word truncated to 7 bits.
  function automatic logic [70:0] elem_of(input int idx);
    logic [31:0] w0, w1, w2;
    w0 = mem[3 * idx];
    w1 = mem[3 * idx + 1];
    w2 = mem[3 * idx + 2];
    return {w2[6:0], w1, w0};
  endfunction

  task automatic wait_xfers(input int n, input int budget);
    int t = 0;
    while (xfer_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("xfer_count", xfer_q.size(), n);
  endtask

  task automatic check_fetch(input int b, input int idx);
    for (int k = 0; k < 3; k++) begin
      chk("fetch_is_read", xfer_q[b + k].wr, 1'b0);
      chk("fetch_addr", xfer_q[b + k].addr, HT_BASE + 32'(3 * idx + k));
    end
    chk("h_element", h_element, elem_of(idx));
    $display("fetch idx=%0d element=%h at cycle %0d", idx, h_element, cyc);
  endtask

  task automatic check_writes(input int b, input logic [7:0] ch, input logic [127:0] path);
    for (int k = 0; k < 4; k++) begin
      chk("write_is_write", xfer_q[b + k].wr, 1'b1);
      chk("write_addr", xfer_q[b + k].addr, CB_BASE + 32'(4 * int'(ch) + k));
      chk("write_data", xfer_q[b + k].data, path[32 * k +: 32]);
    end
    $display("store char=%h path=%h at cycle %0d", ch, path, cyc);
  endtask

  // Raise char_found (starting at a falling edge) and hold it until the
  // controller acknowledges, as synthesis does while in SEND.
  task automatic do_char(input logic [7:0] ch, input logic [127:0] path,
                         output int c0, output int wf_stamp);
    int t = 0;
    char_index = ch;
    char_path  = path;
    char_found = 1'b1;
    c0 = cyc;
    do begin
      @(negedge clk);
      t++;
    end while (!write_finish && t < 80);
    chk("write_finish_seen", write_finish, 1'b1);
    wf_stamp   = cyc;
    char_found = 1'b0;
  endtask

  initial begin
    int b, c0, wfs, wf0, h0, cur_idx, nidx;
    logic [70:0]  held;
    logic [7:0]   ch;
    logic [127:0] path;

    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[15] = 32'hAAAA_5555;
    mem[16] = 32'h1234_5678;
    mem[17] = 32'hFFFF_FF7F;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_h_element", h_element, '0);
    chk("rst_addr_wdata", {mem_addr, mem_wdata}, '0);
    chk("rst_strobes_flags", {mem_rd, mem_wr, write_finish, busy, done}, '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_quiet", xfer_q.size(), 0);
    chk("idle_busy", busy, 1'b0);

    // A: fetch of root 5, no stalls
    b = xfer_q.size();
    max_index = 7'd5; cb_index = 7'd5; start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_xfers(b + 3, 40);
    check_fetch(b, 5);
    chk("a_element_literal", h_element, {7'h7F, 32'h1234_5678, 32'hAAAA_5555});
    chk("a_fetch_latency", xfer_q[b + 2].stamp - (c0 + 1), 3);
    chk("a_busy_done", {busy, done}, 2'b10);

    // B: store char 0x41, path 5
    b = xfer_q.size(); held = h_element; wf0 = wf_cnt;
    do_char(8'h41, 128'h5, c0, wfs);
    wait_xfers(b + 4, 5);
    check_writes(b, 8'h41, 128'h5);
    chk("b_wf_latency", wfs - c0, 5);
    repeat (3) @(negedge clk);
    chk("b_wf_single_pulse", wf_cnt - wf0, 1);
    chk("b_element_kept", h_element, held);

    // C: two stall cycles per transfer, refetch index 2
    stall_mode = 1; h0 = hold_cnt;
    b = xfer_q.size();
    cb_index = 7'd2; c0 = cyc;
    wait_xfers(b + 3, 60);
    check_fetch(b, 2);
    chk("c_fetch_latency", xfer_q[b + 2].stamp - (c0 + 1), 9);
    b = xfer_q.size(); path = {$urandom, $urandom, $urandom, $urandom};
    do_char(8'hC3, path, c0, wfs);
    check_writes(b, 8'hC3, path);
    chk("c_wf_latency", wfs - c0, 13);
    chk("c_stalls_seen", hold_cnt > h0, 1'b1);
    chk("c_strobe_hold", hold_bad, 0);

    // D: cb_index change together with char_found; write first, then fetch
    stall_mode = 2;
    @(negedge clk);
    b = xfer_q.size();
    cb_index = 7'd5;
    wait_xfers(b + 3, 60);
    check_fetch(b, 5);
    b = xfer_q.size(); path = {$urandom, $urandom, $urandom, $urandom};
    cb_index = 7'd2;
    do_char(8'h7E, path, c0, wfs);
    wait_xfers(b + 7, 60);
    check_writes(b, 8'h7E, path);
    chk("d_fetch_after_write", xfer_q[b + 4].stamp > wfs, 1'b1);
    for (int k = 0; k < 3; k++) chk("d_fetch_addr", xfer_q[b + 4 + k].addr, 32'(6 + k));
    chk("d_element", h_element, elem_of(2));
    chk("d_strobe_hold", hold_bad, 0);

    // E: reset during the second write, then restart from max_index
    stall_mode = 0;
    @(negedge clk);
    b = xfer_q.size();
    char_index = 8'h10; char_path = {$urandom, $urandom, $urandom, $urandom};
    char_found = 1'b1;
    for (int t = 0; t < 20 && xfer_q.size() < b + 1; t++) @(negedge clk);
    chk("e_first_write", xfer_q.size(), b + 1);
    chk("e_second_write_pending", {mem_wr, mem_addr}, {1'b1, CB_BASE + 32'h41});
    rst = 1'b1;
    #1;
    chk("e_rst_h_element", h_element, '0);
    chk("e_rst_addr_wdata", {mem_addr, mem_wdata}, '0);
    chk("e_rst_strobes_flags", {mem_rd, mem_wr, write_finish, busy, done}, '0);
    char_found = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("e_no_retry", xfer_q.size(), b + 1);
    chk("e_idle_busy", busy, 1'b0);
    b = xfer_q.size();
    max_index = 7'd5; cb_index = 7'd5; start = 1'b1;
    @(negedge clk);
    // A start while already busy must not redirect the fetch.
    max_index = 7'd9;
    @(negedge clk);
    start = 1'b0; max_index = 7'd5;
    wait_xfers(b + 3, 40);
    check_fetch(b, 5);

    // F: cb_finished wins over char_found -> DONE without writes
    @(negedge clk);
    b = xfer_q.size();
    char_found = 1'b1; cb_finished = 1'b1; char_index = 8'h22;
    @(negedge clk);
    char_found = 1'b0; cb_finished = 1'b0;
    chk("f_done", {busy, done}, 2'b01);
    char_found = 1'b1;
    repeat (5) @(negedge clk);
    char_found = 1'b0;
    chk("f_no_writes", xfer_q.size(), b);
    chk("f_no_strobes", {mem_rd, mem_wr, done}, 3'b001);
    max_index = 7'd3; cb_index = 7'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_xfers(b + 3, 40);
    check_fetch(b, 3);
    cur_idx = 3;

    // Random mix of refetches and stores with random stalls
    stall_mode = 2;
    for (int it = 0; it < 24; it++) begin
      @(negedge clk);
      b = xfer_q.size();
      if ($urandom_range(0, 1) == 0) begin
        do nidx = int'($urandom_range(0, 127)); while (nidx == cur_idx);
        cb_index = 7'(nidx); cur_idx = nidx;
        wait_xfers(b + 3, 60);
        check_fetch(b, cur_idx);
      end else begin
        ch = 8'($urandom); path = {$urandom, $urandom, $urandom, $urandom};
        held = h_element;
        do_char(ch, path, c0, wfs);
        wait_xfers(b + 4, 5);
        check_writes(b, ch, path);
        chk("r_wf_after_last_write", wfs, xfer_q[b + 3].stamp);
        @(negedge clk);
        chk("r_element_kept", h_element, held);
      end
    end
    chk("r_strobe_hold", hold_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
